mandel_frame_scheduler: RTL
===========================

Name: mandel_frame_scheduler

Overview:
- Sequences one full-frame Mandelbrot render.
- Walks every pixel in raster order, issues (c_re, c_im) requests to the iteration engine over a valid/ready handshake, and collects in-order iteration counts.
- Writes the resulting colour into the framebuffer that the 640x480 VGA path scans out.
- Bounds in-flight requests so the engine's result queue never overflows.

Parameters:
- H_RES, 640, pixels per line
- V_RES, 480, lines per frame
- CW, 32, coordinate width, signed fixed point Q4.(CW-4)
- ITER_W, 8, iteration-count width
- MAX_ITER, 255, engine iteration limit; count equal to this means "in set"
- PIX_W, 4, framebuffer pixel width
- ADDR_W, 19, framebuffer address width
- MAX_OUT, 4, maximum outstanding requests (1..15)

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  pulse: begin a frame render
- i_re_min  in  CW  real coordinate of x=0, latched on accepted start
- i_im_max  in  CW  imaginary coordinate of y=0, latched on accepted start
- i_step  in  CW  coordinate increment per pixel/line, latched on accepted start
- o_busy  out  1  render in progress
- o_done  out  1  one-cycle pulse at frame completion
- o_req_valid  out  1  request valid
- i_req_ready  in  1  engine accepts request
- o_req_re  out  CW  request real coordinate
- o_req_im  out  CW  request imaginary coordinate
- i_rsp_valid  in  1  engine result valid (in order, no backpressure)
- i_rsp_iter  in  ITER_W  iteration count
- o_fb_we  out  1  framebuffer write enable
- o_fb_addr  out  ADDR_W  framebuffer write address
- o_fb_data  out  PIX_W  framebuffer write data
- o_err  out  1  sticky: response received with zero outstanding

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; outstanding count 0; x, y and write address 0.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - i_start=1 latches re_min, im_max and step.
  - Sets req_re=re_min, req_im=im_max, x=y=0.
  - Goes to ISSUE; o_busy=1 from the next cycle.
- i_start while not IDLE is ignored.
- ISSUE:
  - o_req_valid=1 while outstanding<MAX_OUT.
  - A transfer occurs when valid and ready are both high. On a transfer:
    - outstanding increments.
    - x increments and req_re += step.
    - At x=H_RES-1: x←0, req_re←re_min, y increments, req_im -= step.
  - Coordinate arithmetic wraps modulo 2^CW; no saturation.
  - o_req_re and o_req_im must stay stable while valid is high and ready is low.
  - After the transfer of pixel (H_RES-1, V_RES-1), go to DRAIN; o_req_valid=0 from the next cycle.
- Response handling (ISSUE and DRAIN):
  - i_rsp_valid=1 with outstanding>0 decrements outstanding.
  - Next cycle (1-cycle latency): o_fb_we=1, o_fb_addr=write address, o_fb_data = 0 if iter==MAX_ITER, else iter[ITER_W-1 -: PIX_W].
  - Write address then increments; it is linear, y*H_RES+x.
- Simultaneous request transfer and response in the same cycle: outstanding is unchanged.
- i_rsp_valid with outstanding==0 in any state: the response is dropped, no write occurs, and o_err is set (sticky until reset).
- DRAIN: when outstanding==0 and the final write has been issued, go to DONE.
- DONE: o_done=1 for one cycle, o_busy=0, then IDLE.
- Reset mid-frame: immediate return to IDLE with all counters cleared. No write occurs in the reset cycle or after it. The engine is reset by the same i_rst.
- Frame total is H_RES*V_RES writes exactly; the write address never exceeds H_RES*V_RES-1.

Decomposition:
- Package mandel_pkg:
  - CW, ITER_W, PIX_W, H_RES, V_RES, ADDR_W constants
  - fixed-point format definition
  - FSM state enum
- Sub-module mandel_coord_gen: the x/y counters and re/im accumulators with advance and restart inputs, plus last-pixel flag.
- FSM, outstanding counter, colour map and write port stay in the top level.

Test Plan:
- Basic frame: H_RES=4, V_RES=3, re_min=0x E0000000, im_max=0x10000000, step=0x08000000, engine ready=1, fixed 3-cycle response latency, iter=x+y.
  - Expect 12 requests with re sequence E0,E8,F0,F8 (upper byte) per line and im 10,08,00.
  - Expect 12 writes at addr 0..11 with data = top PIX_W bits of iter.
  - o_done pulses once and o_busy drops the same cycle.
- Backpressure and credit limit: i_req_ready toggling 1/0 randomly, responses withheld.
  - o_req_valid falls after exactly MAX_OUT=4 transfers.
  - Coordinates are held stable through ready=0.
  - Issue resumes on the first response.
- Colour map: iter=MAX_ITER=255 → o_fb_data=0; iter=0xA7 → 0xA.
- Simultaneous transfer and response every cycle at outstanding=2: outstanding stays 2 and writes are contiguous.
- Protocol edges:
  - i_start during ISSUE is ignored (latched coordinates unchanged).
  - Spurious i_rsp_valid in IDLE produces o_err=1 and no o_fb_we.
- Reset at pixel 7 of a 12-pixel frame:
  - Next cycle all outputs are 0 and no write occurs.
  - A new start renders all 12 pixels from addr 0.

Source files
------------

// File: rtl/mandel_pkg.sv
// mandel_pkg: shared constants, fixed-point coordinate type and scheduler FSM states
package mandel_pkg;
    localparam int CW       = 32;
    localparam int ITER_W   = 8;
    localparam int PIX_W    = 4;
    localparam int H_RES    = 640;
    localparam int V_RES    = 480;
    localparam int ADDR_W   = 19;
    localparam int MAX_ITER = 255;
    localparam int MAX_OUT  = 4;
    localparam int INT_W    = 4;
    localparam int FRAC_W   = CW - INT_W;
    typedef logic signed [CW-1:0] coord_t;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
endpackage

// File: rtl/mandel_coord_gen.sv
// mandel_coord_gen: raster x/y counters with wrapping re/im coordinate accumulators
module mandel_coord_gen #(
    parameter int H_RES = mandel_pkg::H_RES,
    parameter int V_RES = mandel_pkg::V_RES,
    parameter int CW    = mandel_pkg::CW
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_restart,
    input  logic          i_advance,
    input  logic [CW-1:0] i_re_min,
    input  logic [CW-1:0] i_im_max,
    input  logic [CW-1:0] i_step,
    output logic [CW-1:0] o_re,
    output logic [CW-1:0] o_im,
    output logic          o_last
);
    localparam int XW = $clog2(H_RES);
    localparam int YW = $clog2(V_RES);
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [CW-1:0] re_q, re_d, im_q, im_d, re_min_q, re_min_d, step_q, step_d;
    logic end_x, wrap;
    assign end_x  = x_q == XW'(H_RES - 1);
    assign wrap   = i_advance && end_x;
    assign o_last = end_x && y_q == YW'(V_RES - 1);
    assign o_re   = re_q;
    assign o_im   = im_q;
    // next position: restart reloads the frame origin, advance steps right and wraps to the next line
    always_comb begin
        re_min_d = i_restart ? i_re_min : re_min_q;
        step_d   = i_restart ? i_step : step_q;
        x_d      = i_restart ? '0 : !i_advance ? x_q : end_x ? '0 : x_q + XW'(1);
        y_d      = i_restart ? '0 : !wrap ? y_q : o_last ? '0 : y_q + YW'(1);
        re_d     = i_restart ? i_re_min : !i_advance ? re_q : end_x ? re_min_q : re_q + step_q;
        im_d     = i_restart ? i_im_max : wrap ? im_q - step_q : im_q;
    end
    // position and coordinate registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            x_q      <= '0;
            y_q      <= '0;
            re_q     <= '0;
            im_q     <= '0;
            re_min_q <= '0;
            step_q   <= '0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            re_q     <= re_d;
            im_q     <= im_d;
            re_min_q <= re_min_d;
            step_q   <= step_d;
        end
    end
endmodule

// File: rtl/mandel_frame_scheduler.sv
// mandel_frame_scheduler: issues per-pixel engine requests under a credit limit and writes colours to the framebuffer
module mandel_frame_scheduler #(
    parameter int H_RES    = mandel_pkg::H_RES,
    parameter int V_RES    = mandel_pkg::V_RES,
    parameter int CW       = mandel_pkg::CW,
    parameter int ITER_W   = mandel_pkg::ITER_W,
    parameter int MAX_ITER = mandel_pkg::MAX_ITER,
    parameter int PIX_W    = mandel_pkg::PIX_W,
    parameter int ADDR_W   = mandel_pkg::ADDR_W,
    parameter int MAX_OUT  = mandel_pkg::MAX_OUT
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [CW-1:0]     i_re_min,
    input  logic [CW-1:0]     i_im_max,
    input  logic [CW-1:0]     i_step,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_req_valid,
    input  logic              i_req_ready,
    output logic [CW-1:0]     o_req_re,
    output logic [CW-1:0]     o_req_im,
    input  logic              i_rsp_valid,
    input  logic [ITER_W-1:0] i_rsp_iter,
    output logic              o_fb_we,
    output logic [ADDR_W-1:0] o_fb_addr,
    output logic [PIX_W-1:0]  o_fb_data,
    output logic              o_err
);
    import mandel_pkg::*;
    localparam int OW = $clog2(MAX_OUT + 1);
    state_t state_q, state_d;
    logic [OW-1:0] out_q, out_d;
    logic [ADDR_W-1:0] wa_q, wa_d, addr_q;
    logic [PIX_W-1:0] data_q;
    logic we_q, err_q, fire, rsp_ok, start_ok, last;
    assign start_ok    = state_q == IDLE && i_start;
    assign o_req_valid = state_q == ISSUE && out_q < OW'(MAX_OUT);
    assign fire        = o_req_valid && i_req_ready;
    assign rsp_ok      = i_rsp_valid && out_q != '0;
    assign out_d       = out_q + OW'(fire) - OW'(rsp_ok);
    assign wa_d        = start_ok ? '0 : wa_q + ADDR_W'(rsp_ok);
    assign o_fb_we     = we_q;
    assign o_fb_addr   = addr_q;
    assign o_fb_data   = data_q;
    assign o_err       = err_q;

    mandel_coord_gen #(.H_RES(H_RES), .V_RES(V_RES), .CW(CW)) u_coord (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_restart(start_ok),
        .i_advance(fire),
        .i_re_min (i_re_min),
        .i_im_max (i_im_max),
        .i_step   (i_step),
        .o_re     (o_req_re),
        .o_im     (o_req_im),
        .o_last   (last)
    );

    // frame sequencing: drain waits for every outstanding result before signalling completion
    always_comb begin
        state_d = state_q;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        case (state_q)
            IDLE: state_d = i_start ? ISSUE : IDLE;
            ISSUE: begin
                o_busy  = 1'b1;
                state_d = fire && last ? DRAIN : ISSUE;
            end
            DRAIN: begin
                o_busy  = 1'b1;
                state_d = out_q == '0 ? DONE : DRAIN;
            end
            default: begin
                o_done  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // state, credit count and registered framebuffer write port; MAX_ITER maps to black
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            wa_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            wa_q    <= wa_d;
            we_q    <= rsp_ok;
            err_q   <= err_q || (i_rsp_valid && out_q == '0);
            if (rsp_ok) begin
                addr_q <= wa_q;
                data_q <= i_rsp_iter == ITER_W'(MAX_ITER) ? '0 : i_rsp_iter[ITER_W-1 -: PIX_W];
            end
        end
    end
endmodule
